// File: rtl/fk_seq_engine_if.sv
// Command, trig-table and result signals of the two-link SCARA forward-kinematics engine.
// The engine takes the slave side; the command source, lookup table and consumer take master.
interface fk_seq_engine_if #(
  parameter int ANG_W     = 9,
  parameter int L_W       = 14,
  parameter int TRIG_FRAC = 14
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [ANG_W-1:0]     th1;
  logic signed [ANG_W-1:0]     th2;
  logic        [L_W-1:0]       l1;
  logic        [L_W-1:0]       l2;
  logic signed [ANG_W-1:0]     trig_angle;
  logic signed [TRIG_FRAC+1:0] trig_sin;
  logic signed [TRIG_FRAC+1:0] trig_cos;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [L_W+1:0]       x;
  logic signed [L_W+1:0]       y;
  logic                        err;

  modport slave (
    input  in_valid, th1, th2, l1, l2, trig_sin, trig_cos, out_ready,
    output in_ready, trig_angle, out_valid, x, y, err
  );
  modport master (
    output in_valid, th1, th2, l1, l2, trig_sin, trig_cos, out_ready,
    input  in_ready, trig_angle, out_valid, x, y, err
  );
endinterface

// File: rtl/fk_seq_engine.sv
// Two-link SCARA forward kinematics: x/y from link lengths and joint angles.
// One pipelined multiplier is time-shared across the four link*trig products.
module fk_seq_engine #(
  parameter int ANG_W     = 9,
  parameter int L_W       = 14,
  parameter int TRIG_FRAC = 14,
  parameter int MUL_LAT   = 2
) (
  input logic            clk,
  input logic            reset,
  fk_seq_engine_if.slave bus
);
  localparam int T_W   = TRIG_FRAC + 2;
  localparam int P_W   = L_W + TRIG_FRAC + 2;
  localparam int A_W   = P_W + 1;
  localparam int S_W   = ANG_W + 1;
  localparam int CNT_W = $clog2(MUL_LAT + 4) + 1;

  localparam logic signed [ANG_W-1:0] A_MIN  = ANG_W'(-180);
  localparam logic signed [ANG_W-1:0] A_MAX  = ANG_W'(179);
  localparam logic signed [S_W-1:0]   S_P180 = S_W'(180);
  localparam logic signed [S_W-1:0]   S_N180 = S_W'(-180);
  localparam logic signed [S_W-1:0]   S_360  = S_W'(360);
  localparam logic signed [A_W-1:0]   HALF   = A_W'(1) << (TRIG_FRAC - 1);

  typedef enum logic [2:0] {IDLE, TRIG1, TRIG12, ISSUE, DRAIN, SUM, DONE} state_t;
  state_t r_state, w_next;

  logic signed [ANG_W-1:0] r_th1, r_th2, r_trig_angle;
  logic        [L_W-1:0]   r_l1, r_l2;
  logic signed [T_W-1:0]   r_sin1, r_cos1, r_sin12, r_cos12;
  logic        [CNT_W-1:0] r_cnt;
  logic signed [P_W-1:0]   r_mp [MUL_LAT];
  logic        [MUL_LAT-1:0] r_vld_pipe, r_sel_pipe;
  logic signed [A_W-1:0]   r_accx, r_accy;
  logic signed [L_W+1:0]   r_x, r_y;
  logic                    r_err;

  logic                    w_accept, w_oor, w_issue, w_unused;
  logic signed [S_W-1:0]   w_sum, w_wrap;
  logic        [L_W-1:0]   w_l;
  logic signed [T_W-1:0]   w_t;
  logic signed [L_W:0]     w_a;
  logic signed [P_W-1:0]   w_prod;
  logic signed [A_W-1:0]   w_pext, w_xr, w_yr;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_issue  = (r_state == ISSUE);
  assign w_oor    = (r_th1 < A_MIN) || (r_th1 > A_MAX) || (r_th2 < A_MIN) || (r_th2 > A_MAX);

  // Sum one bit wider than the angles so the wrap test sees the true value.
  assign w_sum  = {r_th1[ANG_W-1], r_th1} + {r_th2[ANG_W-1], r_th2};
  assign w_wrap = (w_sum >= S_P180) ? w_sum - S_360 :
                  (w_sum <  S_N180) ? w_sum + S_360 : w_sum;

  always_comb begin
    w_l = r_l1;
    w_t = r_cos1;
    case (r_cnt[1:0])
      2'd0:    begin w_l = r_l1; w_t = r_cos1;  end
      2'd1:    begin w_l = r_l2; w_t = r_cos12; end
      2'd2:    begin w_l = r_l1; w_t = r_sin1;  end
      default: begin w_l = r_l2; w_t = r_sin12; end
    endcase
  end

  assign w_a    = {1'b0, w_l};
  assign w_prod = $signed(P_W'(w_a)) * $signed(P_W'(w_t));
  assign w_pext = {r_mp[MUL_LAT-1][P_W-1], r_mp[MUL_LAT-1]};
  assign w_xr   = r_accx + HALF;
  assign w_yr   = r_accy + HALF;
  assign w_unused = ^{w_wrap[ANG_W], w_xr[A_W-1], w_xr[TRIG_FRAC-1:0],
                      w_yr[A_W-1], w_yr[TRIG_FRAC-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = TRIG1;
      TRIG1:   w_next = TRIG12;
      TRIG12:  w_next = w_oor ? DONE : ISSUE;
      ISSUE:   if (r_cnt == CNT_W'(3)) w_next = DRAIN;
      DRAIN:   if (r_cnt == CNT_W'(MUL_LAT - 1)) w_next = SUM;
      SUM:     w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Products leave the last stage tagged x (indices 0,1) or y (2,3).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MUL_LAT; k++) r_mp[k] <= '0;
      r_vld_pipe <= '0;
      r_sel_pipe <= '0;
      r_accx     <= '0;
      r_accy     <= '0;
    end else begin
      r_mp[0]       <= w_prod;
      r_vld_pipe[0] <= w_issue;
      r_sel_pipe[0] <= r_cnt[1];
      for (int k = 1; k < MUL_LAT; k++) begin
        r_mp[k]       <= r_mp[k-1];
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_sel_pipe[k] <= r_sel_pipe[k-1];
      end
      if (w_accept) begin
        r_accx <= '0;
        r_accy <= '0;
      end else if (r_vld_pipe[MUL_LAT-1]) begin
        if (r_sel_pipe[MUL_LAT-1]) r_accy <= r_accy + w_pext;
        else                       r_accx <= r_accx + w_pext;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th1 <= '0; r_th2 <= '0; r_l1 <= '0; r_l2 <= '0;
      r_trig_angle <= '0;
      r_sin1 <= '0; r_cos1 <= '0; r_sin12 <= '0; r_cos12 <= '0;
      r_cnt <= '0;
      r_x <= '0; r_y <= '0; r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_th1 <= bus.th1; r_th2 <= bus.th2;
        r_l1  <= bus.l1;  r_l2  <= bus.l2;
        r_trig_angle <= bus.th1;
      end
      if (r_state == TRIG1) begin
        r_sin1 <= bus.trig_sin;
        r_cos1 <= bus.trig_cos;
        r_trig_angle <= w_wrap[ANG_W-1:0];
      end
      if (r_state == TRIG12) begin
        r_sin12 <= bus.trig_sin;
        r_cos12 <= bus.trig_cos;
        if (w_oor) begin
          r_x <= '0; r_y <= '0; r_err <= 1'b1;
        end
      end
      if (r_state == SUM) begin
        r_x   <= w_xr[TRIG_FRAC +: L_W+2];
        r_y   <= w_yr[TRIG_FRAC +: L_W+2];
        r_err <= 1'b0;
      end
      if ((r_state == ISSUE || r_state == DRAIN) && w_next == r_state) r_cnt <= r_cnt + CNT_W'(1);
      else                                                             r_cnt <= '0;
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.trig_angle = r_trig_angle;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_fk_seq_engine.sv
// Bench for fk_seq_engine: directed test-plan cases, randomized commands, hold and reset abort,
// checked against an arithmetic model built on an exact-rounded degree sin/cos table.
module tb_fk_seq_engine;
  localparam int ANG_W = 9, L_W = 14, TF = 14, ML = 2;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fk_seq_engine_if #(.ANG_W(ANG_W), .L_W(L_W), .TRIG_FRAC(TF)) bus();
  fk_seq_engine #(.ANG_W(ANG_W), .L_W(L_W), .TRIG_FRAC(TF), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  function automatic int tsin(int a);
    real v;
    v = $sin(a * PI / 180.0) * 16384.0;
    return $rtoi($floor(v + 0.5));
  endfunction
  function automatic int tcos(int a);
    real v;
    v = $cos(a * PI / 180.0) * 16384.0;
    return $rtoi($floor(v + 0.5));
  endfunction
  function automatic int wrap(int s);
    if (s >= 180) return s - 360;
    if (s < -180) return s + 360;
    return s;
  endfunction
  function automatic int rnd(longint acc);
    longint r;
    logic signed [15:0] t;
    r = (acc + 8192) >>> 14;
    t = 16'(r);
    return int'(t);
  endfunction

  // Lookup table answers combinationally for whatever angle the engine presents.
  assign bus.trig_sin = 16'(tsin(int'(bus.trig_angle)));
  assign bus.trig_cos = 16'(tcos(int'(bus.trig_angle)));

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic scramble();
    bus.th1 = ANG_W'($urandom);
    bus.th2 = ANG_W'($urandom);
    bus.l1  = L_W'($urandom);
    bus.l2  = L_W'($urandom);
  endtask

  task automatic run_cmd(string tag, int t1, int t2, int a1, int a2, int hold, bit gold);
    int guard, lat, s, ex, ey, hx, hy;
    bit oor;
    real rx, ry;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin tick(); guard++; end
    chk({tag, ":rdy"}, 32'(bus.in_ready), 1);
    oor = (t1 < -180) || (t1 > 179) || (t2 < -180) || (t2 > 179);
    s  = wrap(t1 + t2);
    ex = oor ? 0 : rnd(longint'(a1) * tcos(t1) + longint'(a2) * tcos(s));
    ey = oor ? 0 : rnd(longint'(a1) * tsin(t1) + longint'(a2) * tsin(s));
    bus.th1 = ANG_W'(t1); bus.th2 = ANG_W'(t2);
    bus.l1 = L_W'(a1); bus.l2 = L_W'(a2);
    bus.in_valid = 1'b1;
    tick();
    // Busy: inputs wander and in_valid pulses; none of it may disturb this command.
    bus.in_valid = 1'($urandom);
    scramble();
    chk({tag, ":busy"}, 32'(bus.in_ready), 0);
    if (!oor) chk({tag, ":ang1"}, 32'(bus.trig_angle), t1);
    tick();
    lat = 1;
    if (!oor) chk({tag, ":ang12"}, 32'(bus.trig_angle), s);
    while (!bus.out_valid && lat < 60) begin
      bus.in_valid = 1'($urandom);
      scramble();
      tick();
      lat++;
    end
    chk({tag, ":lat"}, lat, oor ? 2 : 7 + ML);
    chk({tag, ":x"}, 32'(bus.x), ex);
    chk({tag, ":y"}, 32'(bus.y), ey);
    chk({tag, ":err"}, 32'(bus.err), 32'(oor));
    if (gold) begin
      rx = a1 * $cos(t1 * PI / 180.0) + a2 * $cos(s * PI / 180.0);
      ry = a1 * $sin(t1 * PI / 180.0) + a2 * $sin(s * PI / 180.0);
      hx = int'(bus.x) - $rtoi($floor(rx + 0.5));
      hy = int'(bus.y) - $rtoi($floor(ry + 0.5));
      chk({tag, ":goldx"}, 32'((hx <= 1) && (hx >= -1)), 1);
      chk({tag, ":goldy"}, 32'((hy <= 1) && (hy >= -1)), 1);
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      scramble();
      tick();
      chk({tag, ":hold_v"}, 32'(bus.out_valid), 1);
      chk({tag, ":hold_rdy"}, 32'(bus.in_ready), 0);
      chk({tag, ":hold_x"}, 32'(bus.x), ex);
      chk({tag, ":hold_y"}, 32'(bus.y), ey);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, ":post_v"}, 32'(bus.out_valid), 0);
    chk({tag, ":post_rdy"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    int seen, r1, r2;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.th1 = '0; bus.th2 = '0; bus.l1 = '0; bus.l2 = '0;
    #3;
    chk("rst_rdy", 32'(bus.in_ready), 1);
    chk("rst_v", 32'(bus.out_valid), 0);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_ang", 32'(bus.trig_angle), 0);
    #9 reset = 1'b0;
    tick();

    run_cmd("zero",   0,   0, 100,  50, 0, 0);
    chk("zero_xc", 32'(bus.x), 150);
    chk("zero_yc", 32'(bus.y), 0);
    run_cmd("ninety", 90,  0, 200, 100, 0, 0);
    chk("ninety_xc", 32'(bus.x), 0);
    chk("ninety_yc", 32'(bus.y), 300);
    run_cmd("diag",   45, 45, 100, 100, 0, 0);
    chk("diag_xc", 32'(bus.x), 71);
    chk("diag_yc", 32'(bus.y), 171);
    run_cmd("wrap_p", 170,  20, 1234, 567, 0, 1);
    run_cmd("wrap_n", -170, -20, 800, 16383, 0, 1);
    run_cmd("oor_th1", 180,   0, 100, 100, 0, 0);
    run_cmd("after1",  30,   60, 300, 200, 0, 1);
    run_cmd("oor_th2", 10, -181, 100, 100, 0, 0);
    run_cmd("edge",  -180,  179, 16383, 16383, 0, 1);
    run_cmd("hold",   -45, 120, 5000, 3000, 20, 1);
    run_cmd("second", 60, -30, 700, 900, 0, 1);

    // Abort in the middle of ISSUE with an asynchronous reset pulse.
    bus.th1 = 9'sd33; bus.th2 = 9'sd77; bus.l1 = 14'd4000; bus.l2 = 14'd2500;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_v", 32'(bus.out_valid), 0);
    chk("abort_rdy", 32'(bus.in_ready), 1);
    chk("abort_x", 32'(bus.x), 0);
    chk("abort_y", 32'(bus.y), 0);
    chk("abort_err", 32'(bus.err), 0);
    chk("abort_ang", 32'(bus.trig_angle), 0);
    #1 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("abort_noout", seen, 0);
    run_cmd("post_abort", 33, 77, 4000, 2500, 0, 1);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(4) == 0) begin
        r1 = int'($urandom_range(511)) - 256;
        r2 = int'($urandom_range(511)) - 256;
      end else begin
        r1 = int'($urandom_range(359)) - 180;
        r2 = int'($urandom_range(359)) - 180;
      end
      run_cmd($sformatf("rand%0d", n), r1, r2, int'($urandom_range(16383)),
              int'($urandom_range(16383)), int'($urandom_range(3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
